// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants, state encoding and divider helper for the SPI master
// Optional feature macro: SPI_MASTER_BURST_EN (adds the LINGER state).
package spi_pkg;

    localparam int SPI_BITS    = 8;
    localparam int CLK_DIV_MIN = 2;
    localparam int CLK_DIV_MAX = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD
`ifdef SPI_MASTER_BURST_EN
        , ST_LINGER
`endif
    } spi_state_t;

    // Clamp a divider into its legal range so a bad parameter cannot
    // produce a zero-length (or wrapping) half-period.
    function automatic int legal_div(input int d);
        if (d < CLK_DIV_MIN) return CLK_DIV_MIN;
        if (d > CLK_DIV_MAX) return CLK_DIV_MAX;
        return d;
    endfunction

endpackage

// File: rtl/spi_tick_counter.sv
// rtl/spi_tick_counter.sv - one-cycle tick every CLK_DIV clocks, restartable
// Ports:
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   restart in  restart the count from zero (state entered outside a tick)
//   tick    out high during the last cycle of each CLK_DIV-cycle period
module spi_tick_counter
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(legal_div(CLK_DIV) - 1);

    logic [7:0] cnt;

    assign tick = (cnt == LAST);

    // Wrapping on tick doubles as the restart for tick-driven state changes.
    always_ff @(posedge clk) begin
        if (rst || restart || tick) begin
            cnt <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode 0 master, one byte per start, MSB first
// Optional feature macro: SPI_MASTER_BURST_EN (keep ssel low between bytes).
// Ports:
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   start   in  request to send txData (ignored while busy)
//   txData  in  byte to transmit
//   busy    out transfer in progress
//   done    out one-cycle pulse at end of byte
//   rxData  out last received byte, held until the next done
//   sck     out serial clock, idles low
//   mosi    out serial data out
//   miso    in  serial data in
//   ssel    out active-low slave select
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SPI_BITS-1:0] txData,
    output logic                busy,
    output logic                done,
    output logic [SPI_BITS-1:0] rxData,
    output logic                sck,
    output logic                mosi,
    input  logic                miso,
    output logic                ssel
);

    spi_state_t          state;
    logic                tick;
    logic                accept;
    logic [SPI_BITS-2:0] tx_sr;   // bits still to send after the one on mosi
    logic [SPI_BITS-1:0] rx_sr;
    logic [2:0]          bit_cnt;

    always_comb begin
        accept = 1'b0;
        if (start && state == ST_IDLE) accept = 1'b1;
`ifdef SPI_MASTER_BURST_EN
        if (start && state == ST_LINGER) accept = 1'b1;
`endif
    end

    spi_tick_counter #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (accept),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            ssel    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            rxData  <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= 3'd0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                mosi    <= txData[SPI_BITS-1];
                tx_sr   <= txData[SPI_BITS-2:0];
                ssel    <= 1'b0;
                busy    <= 1'b1;
                bit_cnt <= 3'd0;
                state   <= ST_SETUP;
            end else if (tick) begin
                case (state)
                    ST_SETUP, ST_LOW: begin
                        // Slave drives miso while sck is low; capture on the rise.
                        sck   <= 1'b1;
                        rx_sr <= {rx_sr[SPI_BITS-2:0], miso};
                        state <= ST_HIGH;
                    end
                    ST_HIGH: begin
                        sck     <= 1'b0;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'(SPI_BITS - 1)) begin
                            state <= ST_HOLD;
                        end else begin
                            mosi  <= tx_sr[SPI_BITS-2];
                            tx_sr <= {tx_sr[SPI_BITS-3:0], 1'b0};
                            state <= ST_LOW;
                        end
                    end
                    ST_HOLD: begin
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        rxData <= rx_sr;
`ifdef SPI_MASTER_BURST_EN
                        state  <= ST_LINGER;
`else
                        ssel   <= 1'b1;
                        state  <= ST_IDLE;
`endif
                    end
`ifdef SPI_MASTER_BURST_EN
                    ST_LINGER: begin
                        ssel  <= 1'b1;
                        state <= ST_IDLE;
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start0 = 1'b0;
    logic [7:0] txd0 = 8'h00;
    logic       busy0, done0, sck0, mosi0, ssel0;
    logic [7:0] rxd0;

    logic       start1 = 1'b0;
    logic [7:0] txd1 = 8'h00;
    logic       busy1, done1, sck1, mosi1, ssel1;
    logic [7:0] rxd1;

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(4)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .txData(txd0),
        .busy(busy0), .done(done0), .rxData(rxd0),
        .sck(sck0), .mosi(mosi0), .miso(mosi0), .ssel(ssel0)
    );

    spi_master #(.CLK_DIV(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .txData(txd1),
        .busy(busy1), .done(done1), .rxData(rxd1),
        .sck(sck1), .mosi(mosi1), .miso(mosi1), .ssel(ssel1)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int t_acc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Observers for dut0: sck rises, mosi at each rise, a reference slave,
    // done pulses, mosi changes while sck high, ssel-high cycles in a window.
    logic       sck0_q = 1'b0;
    logic       mosi0_q = 1'b0;
    int         rises0 = 0;
    logic [7:0] bits0 = 8'h00;
    int         dones0 = 0;
    int         mosi_hi_chg = 0;
    logic [7:0] sl_sr = 8'h00;
    int         sl_cnt = 0;
    logic [7:0] sl_q[$];
    bit         win = 1'b0;
    int         ssel_hi = 0;

    always @(negedge clk) begin
        if (sck0 && !sck0_q) begin
            rises0++;
            bits0 = {bits0[6:0], mosi0};
            if (!ssel0) begin
                sl_sr = {sl_sr[6:0], mosi0};
                sl_cnt++;
                if (sl_cnt == 8) begin
                    sl_q.push_back(sl_sr);
                    sl_cnt = 0;
                end
            end
        end
        if (ssel0) sl_cnt = 0;
        if (sck0 && mosi0 !== mosi0_q) mosi_hi_chg++;
        if (done0) dones0++;
        if (win && ssel0) ssel_hi++;
        sck0_q  = sck0;
        mosi0_q = mosi0;
    end

    logic sck1_q = 1'b0;
    int   rise1_t[$];
    always @(negedge clk) begin
        if (sck1 && !sck1_q) rise1_t.push_back(cyc);
        sck1_q = sck1;
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic launch0(input logic [7:0] d);
        start0 = 1'b1;
        txd0   = d;
        @(negedge clk);
        start0 = 1'b0;
        t_acc  = cyc;
    endtask

    task automatic wait_done0(output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (done0) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        else lat = cyc - t_acc;
    endtask

    initial begin
        int lat;
        int d0;
        int r0;
        bit hit;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sck", 32'(sck0), 32'd0);
        chk("rst_mosi", 32'(mosi0), 32'd0);
        chk("rst_ssel", 32'(ssel0), 32'd1);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_rx", 32'(rxd0), 32'h00);
        rst = 1'b0;
        @(negedge clk);

        // A5 loopback
        r0 = rises0;
        d0 = dones0;
        launch0(8'hA5);
        chk("a5_ssel_acc", 32'(ssel0), 32'd0);
        chk("a5_busy_acc", 32'(busy0), 32'd1);
        chk("a5_mosi_acc", 32'(mosi0), 32'd1);
        wait_done0(lat);
        chk("a5_latency", 32'(lat), 32'd68);
        chk("a5_rx", 32'(rxd0), 32'hA5);
        chk("a5_busy_done", 32'(busy0), 32'd0);
        chk("a5_mosi_bits", 32'(bits0), 32'hA5);
        chk("a5_rises", 32'(rises0 - r0), 32'd8);
        @(negedge clk);
        chk("a5_ssel_after", 32'(ssel0), 32'd1);
        chk("a5_sck_idle", 32'(sck0), 32'd0);
        chk("a5_dones", 32'(dones0 - d0), 32'd1);

        // Reference slave receives FF then 00
        sl_q.delete();
        launch0(8'hFF);
        wait_done0(lat);
        repeat (3) @(negedge clk);
        launch0(8'h00);
        wait_done0(lat);
        chk("slave_count", 32'(sl_q.size()), 32'd2);
        if (sl_q.size() == 2) begin
            chk("slave_b0", 32'(sl_q[0]), 32'hFF);
            chk("slave_b1", 32'(sl_q[1]), 32'h00);
        end
        chk("ff00_rx", 32'(rxd0), 32'h00);

        // Start mid-byte is ignored
        repeat (2) @(negedge clk);
        d0 = dones0;
        launch0(8'h96);
        repeat (20) @(negedge clk);
        start0 = 1'b1;
        txd0   = 8'h3C;
        @(negedge clk);
        start0 = 1'b0;
        wait_done0(lat);
        chk("ign_latency", 32'(lat), 32'd68);
        chk("ign_rx", 32'(rxd0), 32'h96);
        chk("ign_bits", 32'(bits0), 32'h96);
        repeat (80) @(negedge clk);
        chk("ign_dones", 32'(dones0 - d0), 32'd1);
        chk("ign_busy", 32'(busy0), 32'd0);

        // Back-to-back: second start in the done cycle
        launch0(8'h5A);
        win = 1'b1;
        wait_done0(lat);
        launch0(8'hC3);
        win = 1'b0;
        chk("b2b_busy2", 32'(busy0), 32'd1);
        wait_done0(lat);
        chk("b2b_latency2", 32'(lat), 32'd68);
        chk("b2b_rx2", 32'(rxd0), 32'hC3);
`ifdef SPI_MASTER_BURST_EN
        chk("b2b_ssel_hi", 32'(ssel_hi), 32'd0);
`else
        chk("b2b_ssel_hi", 32'(ssel_hi >= 1), 32'd1);
`endif
        repeat (10) @(negedge clk);
        chk("b2b_ssel_end", 32'(ssel0), 32'd1);

        // CLK_DIV=2, 81 loopback
        rise1_t.delete();
        start1 = 1'b1;
        txd1   = 8'h81;
        @(negedge clk);
        start1 = 1'b0;
        t_acc  = cyc;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (done1) hit = 1'b1;
        end
        chk("d2_done_seen", 32'(hit), 32'd1);
        chk("d2_latency", 32'(cyc - t_acc), 32'd34);
        chk("d2_rx", 32'(rxd1), 32'h81);
        chk("d2_rises", 32'(rise1_t.size()), 32'd8);
        if (rise1_t.size() >= 2) chk("d2_period", 32'(rise1_t[1] - rise1_t[0]), 32'd4);

        // Reset after the 3rd sck rise
        repeat (3) @(negedge clk);
        d0 = dones0;
        r0 = rises0;
        launch0(8'hE7);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (rises0 - r0 >= 3) hit = 1'b1;
        end
        chk("mid_rise3_seen", 32'(hit), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_ssel", 32'(ssel0), 32'd1);
        chk("mid_sck", 32'(sck0), 32'd0);
        chk("mid_busy", 32'(busy0), 32'd0);
        repeat (100) @(negedge clk);
        chk("mid_dones", 32'(dones0 - d0), 32'd0);
        chk("mid_rx", 32'(rxd0), 32'h00);
        chk("mid_rises", 32'(rises0 - r0), 32'd3);

        chk("mosi_stable_hi", 32'(mosi_hi_chg), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
